// File: rtl/rf_pkg.sv
// Shared widths, write-back FSM states and the destination decode helper
// used by the register-file write-back arbiter and its holding slots.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_NREG   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } wb_state_e;

  function automatic logic [RF_NREG-1:0] onehot16(input logic [RF_ADDR_W-1:0] dsel);
    logic [RF_NREG-1:0] v;
    v       = '0;
    v[dsel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding slot: destination, data, full flag and an
// "older" flag marking that this entry was accepted before the other slot's.
module rf_wb_slot
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dsel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  input  logic              other_accept,
  output logic              accept,
  output logic              full,
  output logic              older,
  output logic [ADDR_W-1:0] dsel,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic              older_q, older_d;
  logic [ADDR_W-1:0] dsel_q, dsel_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A granted slot frees up on the same edge, so it may be refilled at once.
  assign in_ready = !clr && (!full_q || grant);
  assign accept   = in_valid && in_ready;

  always_comb begin
    full_d  = full_q;
    older_d = older_q;
    dsel_d  = dsel_q;
    data_d  = data_q;
    if (grant) begin
      full_d  = 1'b0;
      older_d = 1'b0;
    end
    if (accept) begin
      // A fresh entry is never older than anything already waiting; a
      // same-edge acceptance in the other slot leaves both flags clear (tie).
      full_d  = 1'b1;
      older_d = 1'b0;
      dsel_d  = in_dsel;
      data_d  = in_data;
    end else if (full_q && !grant && other_accept) begin
      older_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      full_q  <= 1'b0;
      older_q <= 1'b0;
      dsel_q  <= '0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      older_q <= older_d;
      dsel_q  <= dsel_d;
      data_q  <= data_d;
    end
  end

  assign full  = full_q;
  assign older = older_q;
  assign dsel  = dsel_q;
  assign data  = data_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two write-back producers onto the single register-file write port,
// issuing at most one write per IDLE/ISSUE/GAP sequence (one write per 3 cycles).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dsel,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dsel,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_dec_en,
  output logic [ADDR_W-1:0] rf_dsel,
  output logic [DATA_W-1:0] rf_in,
  output logic [NREG-1:0]   pend_mask,
  output logic [CNT_W-1:0]  wr_count,
  output logic              busy
);

  logic              a_full, a_older, a_accept;
  logic              b_full, b_older, b_accept;
  logic [ADDR_W-1:0] a_dsel_s, b_dsel_s;
  logic [DATA_W-1:0] a_data_s, b_data_s;
  logic              grant_a, grant_b;

  wb_state_e         state_q, state_d;
  logic              dec_en_q, dec_en_d;
  logic [ADDR_W-1:0] rf_dsel_q, rf_dsel_d;
  logic [DATA_W-1:0] rf_in_q, rf_in_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              rr_last_b_q, rr_last_b_d;

  rf_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk          (CLK),
    .clr          (CLR),
    .in_valid     (a_valid),
    .in_ready     (a_ready),
    .in_dsel      (a_dsel),
    .in_data      (a_data),
    .grant        (grant_a),
    .other_accept (b_accept),
    .accept       (a_accept),
    .full         (a_full),
    .older        (a_older),
    .dsel         (a_dsel_s),
    .data         (a_data_s)
  );

  rf_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk          (CLK),
    .clr          (CLR),
    .in_valid     (b_valid),
    .in_ready     (b_ready),
    .in_dsel      (b_dsel),
    .in_data      (b_data),
    .grant        (grant_b),
    .other_accept (a_accept),
    .accept       (b_accept),
    .full         (b_full),
    .older        (b_older),
    .dsel         (b_dsel_s),
    .data         (b_data_s)
  );

  // Only full slot wins; otherwise the older one; on a tie, the side not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE) begin
      if (a_full && !b_full) begin
        grant_a = 1'b1;
      end else if (b_full && !a_full) begin
        grant_b = 1'b1;
      end else if (a_full && b_full) begin
        if (a_older)          grant_a = 1'b1;
        else if (b_older)     grant_b = 1'b1;
        else if (rr_last_b_q) grant_a = 1'b1;
        else                  grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dec_en_d    = 1'b0;
    rf_dsel_d   = rf_dsel_q;
    rf_in_d     = rf_in_q;
    wr_cnt_d    = wr_cnt_q;
    rr_last_b_d = rr_last_b_q;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d     = ISSUE;
          dec_en_d    = 1'b1;
          rf_dsel_d   = grant_a ? a_dsel_s : b_dsel_s;
          rf_in_d     = grant_a ? a_data_s : b_data_s;
          wr_cnt_d    = wr_cnt_q + CNT_W'(1);
          rr_last_b_d = grant_b;
        end
      end
      // GAP forces the enable low so the decoder always sees a fresh rising edge.
      ISSUE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= IDLE;
      dec_en_q    <= 1'b0;
      rf_dsel_q   <= '0;
      rf_in_q     <= '0;
      wr_cnt_q    <= '0;
      rr_last_b_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      dec_en_q    <= dec_en_d;
      rf_dsel_q   <= rf_dsel_d;
      rf_in_q     <= rf_in_d;
      wr_cnt_q    <= wr_cnt_d;
      rr_last_b_q <= rr_last_b_d;
    end
  end

  assign rf_dec_en = dec_en_q;
  assign rf_dsel   = rf_dsel_q;
  assign rf_in     = rf_in_q;
  assign wr_count  = wr_cnt_q;
  assign busy      = a_full || b_full || (state_q != IDLE);

  // The ISSUE term keeps a destination pending until its write edge has passed.
  assign pend_mask = (a_full ? onehot16(a_dsel_s) : '0)
                   | (b_full ? onehot16(b_dsel_s) : '0)
                   | ((state_q == ISSUE) ? onehot16(rf_dsel_q) : '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed writes push expected issues,
// a negedge monitor pops and compares on every rf_dec_en pulse.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [3:0]  a_dsel = '0, b_dsel = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_dec_en;
  logic [3:0]  rf_dsel;
  logic [31:0] rf_in;
  logic [15:0] pend_mask;
  logic [15:0] wr_count;
  logic        busy;

  typedef struct packed {
    logic [3:0]  dsel;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk  = 0;
  int  n_fail = 0;
  logic prev_en = 1'b0;

  always #5 CLK = ~CLK;

  rf_wb_arbiter dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_dsel    (a_dsel),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_dsel    (b_dsel),
    .b_data    (b_data),
    .rf_dec_en (rf_dec_en),
    .rf_dsel   (rf_dsel),
    .rf_in     (rf_in),
    .pend_mask (pend_mask),
    .wr_count  (wr_count),
    .busy      (busy)
  );

  function automatic wr_t mk(input logic [3:0] d, input logic [31:0] v);
    wr_t w;
    w.dsel = d;
    w.data = v;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every enable pulse must match the next expected write.
  always @(negedge CLK) begin
    if (rf_dec_en === 1'b1) begin
      check("no_back_to_back_en", {31'd0, prev_en}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got R%0d=0x%0h, expected no write", rf_dsel, rf_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_dsel", {28'd0, rf_dsel}, {28'd0, mon_e.dsel});
        check("rf_in", rf_in, mon_e.data);
      end
    end
    prev_en = rf_dec_en;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    int ta, tb, ra, rb;
    logic cur_a, cur_b;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_dec_en", {31'd0, rf_dec_en}, 32'd0);
    check("rst_dsel", {28'd0, rf_dsel}, 32'd0);
    check("rst_rf_in", rf_in, 32'd0);
    check("rst_wr_count", {16'd0, wr_count}, 32'd0);
    check("rst_pend", {16'd0, pend_mask}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
    CLR = 1'b0;
    #1;
    check("ready_after_rst", {30'd0, a_ready, b_ready}, 32'd3);

    // Single uncontended write R5=0x307
    @(negedge CLK);
    a_valid = 1'b1; a_dsel = 4'd5; a_data = 32'h0000_0307;
    exp_q.push_back(mk(4'd5, 32'h0000_0307));
    @(negedge CLK);
    a_valid = 1'b0;
    check("t1_pend_k", {16'd0, pend_mask}, 32'h0020);
    check("t1_en_k", {31'd0, rf_dec_en}, 32'd0);
    @(negedge CLK);
    check("t1_pend_k1", {16'd0, pend_mask}, 32'h0020);
    check("t1_en_k1", {31'd0, rf_dec_en}, 32'd1);
    check("t1_wr_count", {16'd0, wr_count}, 32'd1);
    @(negedge CLK);
    check("t1_pend_k2", {16'd0, pend_mask}, 32'h0000);
    check("t1_en_k2", {31'd0, rf_dec_en}, 32'd0);
    wait_idle();

    // Same-edge tie after reset: A first, B three cycles later
    pulse_clr();
    a_valid = 1'b1; a_dsel = 4'd15; a_data = 32'hFFFF_FFFF;
    b_valid = 1'b1; b_dsel = 4'd4;  b_data = 32'h1400_0006;
    exp_q.push_back(mk(4'd15, 32'hFFFF_FFFF));
    exp_q.push_back(mk(4'd4, 32'h1400_0006));
    @(negedge CLK);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = rf_dec_en;
      if (i < 5) @(negedge CLK);
    end
    check("t2_pulse_pattern", {26'd0, pat}, 32'b010010);
    wait_idle();

    // A alone (last grant A), then a tie goes to B first
    a_valid = 1'b1; a_dsel = 4'd1; a_data = 32'h0000_0011;
    exp_q.push_back(mk(4'd1, 32'h0000_0011));
    @(negedge CLK);
    a_valid = 1'b0;
    wait_idle();
    a_valid = 1'b1; a_dsel = 4'd2; a_data = 32'h0000_0022;
    b_valid = 1'b1; b_dsel = 4'd3; b_data = 32'h0000_0033;
    exp_q.push_back(mk(4'd3, 32'h0000_0033));
    exp_q.push_back(mk(4'd2, 32'h0000_0022));
    @(negedge CLK);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();

    // Same destination R11: A then B one cycle later, B's data lands last
    a_valid = 1'b1; a_dsel = 4'd11; a_data = 32'h0000_BEEF;
    exp_q.push_back(mk(4'd11, 32'h0000_BEEF));
    @(negedge CLK);
    check("t3_pend_k", {16'd0, pend_mask}, 32'h0800);
    a_valid = 1'b0;
    b_valid = 1'b1; b_dsel = 4'd11; b_data = 32'h0000_DEAD;
    exp_q.push_back(mk(4'd11, 32'h0000_DEAD));
    @(negedge CLK);
    b_valid = 1'b0;
    check("t3_pend_k1", {16'd0, pend_mask}, 32'h0800);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("t3_pend_k%0d", i + 2), {16'd0, pend_mask}, (i < 3) ? 32'h0800 : 32'h0000);
    end
    wait_idle();

    // Continuous contention for 30 edges: A1,B1,A2,B2,...,A6,B6
    pulse_clr();
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(4'(k), 32'hA000_0000 | k));
      exp_q.push_back(mk(4'(8 + k), 32'hB000_0000 | k));
    end
    ta = 1; tb = 1; ra = 0; rb = 0;
    for (int i = 0; i < 30; i++) begin
      a_valid = 1'b1; a_dsel = 4'(ta); a_data = 32'hA000_0000 | ta;
      b_valid = 1'b1; b_dsel = 4'(8 + tb); b_data = 32'hB000_0000 | tb;
      #1;
      cur_a = a_ready;
      cur_b = b_ready;
      if (cur_a) ra++;
      if (cur_b) rb++;
      @(negedge CLK);
      if (cur_a) ta++;
      if (cur_b) tb++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("t4_wr_count", {16'd0, wr_count}, 32'd10);
    check("t4_a_ready_cycles", ra, 32'd6);
    check("t4_b_ready_cycles", rb, 32'd6);
    wait_idle();

    // CLR while both slots full and the FSM is in ISSUE
    a_valid = 1'b1; a_dsel = 4'd7; a_data = 32'h0000_0077;
    b_valid = 1'b1; b_dsel = 4'd8; b_data = 32'h0000_0088;
    exp_q.push_back(mk(4'd7, 32'h0000_0077));
    @(negedge CLK);
    b_valid = 1'b0;
    a_dsel = 4'd6; a_data = 32'h0000_0070;
    @(negedge CLK);
    a_valid = 1'b0;
    check("t5_busy_before_clr", {31'd0, busy}, 32'd1);
    CLR = 1'b1;
    @(negedge CLK);
    check("t5_en", {31'd0, rf_dec_en}, 32'd0);
    check("t5_dsel", {28'd0, rf_dsel}, 32'd0);
    check("t5_rf_in", rf_in, 32'd0);
    check("t5_pend", {16'd0, pend_mask}, 32'd0);
    check("t5_wr_count", {16'd0, wr_count}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ready", {30'd0, a_ready, b_ready}, 32'd0);
    CLR = 1'b0;
    repeat (10) @(negedge CLK);
    check("t5_no_leftover_expected", exp_q.size(), 32'd0);

    // Counter wrap
    force dut.wr_cnt_q = 16'hFFFF;
    repeat (2) @(negedge CLK);
    release dut.wr_cnt_q;
    @(negedge CLK);
    check("t6_preset", {16'd0, wr_count}, 32'h0000_FFFF);
    a_valid = 1'b1; a_dsel = 4'd9; a_data = 32'h0000_0099;
    exp_q.push_back(mk(4'd9, 32'h0000_0099));
    @(negedge CLK);
    a_valid = 1'b0;
    @(negedge CLK);
    check("t6_wrap", {16'd0, wr_count}, 32'h0000_0000);
    wait_idle();

    check("all_expected_issued", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
